// File: rtl/score_disp_pkg.sv
// Shared definitions for the score display: segment encoding, blank pattern
// and the conversion FSM state type.
package score_disp_pkg;

   // All segments off (active-low).
   localparam logic [6:0] SEG_BLANK = 7'h7F;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SHIFT  = 2'd1,
      ST_COMMIT = 2'd2
   } conv_state_e;

   // BCD digit to active-low segments {g,f,e,d,c,b,a}; non-decimal codes blank.
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = SEG_BLANK;
      endcase
      return s;
   endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one bit per cycle, VAL_W shift cycles, then a
// one-cycle COMMIT where done_o is high and bcd_o/ovf_o are stable.
module bin2bcd_seq
   import score_disp_pkg::*;
#(
   parameter int VAL_W    = 16,
   parameter int N_DIGITS = 8
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  start_i,
   input  logic [VAL_W-1:0]      value_i,
   output logic                  busy_o,
   output logic                  done_o,
   output logic [4*N_DIGITS-1:0] bcd_o,
   output logic                  ovf_o
);

   localparam int BCD_W = 4 * N_DIGITS;
   localparam int CNT_W = $clog2(VAL_W + 1);

   conv_state_e      state_q;
   logic [BCD_W-1:0] bcd_q;
   logic [BCD_W-1:0] adj_d;
   logic [VAL_W-1:0] bin_q;
   logic [CNT_W-1:0] cnt_q;
   logic             ovf_q;
   logic             busy_q;
   logic             done_q;

   // Add-3 correction on every nibble that will reach 10 or more after the shift.
   always_comb begin
      adj_d = bcd_q;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) adj_d[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
      end
   end

   // Conversion FSM; a 1 leaving the top nibble means the value needs more digits.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= ST_IDLE;
         bcd_q   <= '0;
         bin_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (start_i) begin
                  bin_q   <= value_i;
                  bcd_q   <= '0;
                  cnt_q   <= CNT_W'(VAL_W);
                  ovf_q   <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               bcd_q <= {adj_d[BCD_W-2:0], bin_q[VAL_W-1]};
               bin_q <= {bin_q[VAL_W-2:0], 1'b0};
               ovf_q <= ovf_q | adj_d[BCD_W-1];
               cnt_q <= cnt_q - CNT_W'(1);
               if (cnt_q == CNT_W'(1)) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= ST_COMMIT;
               end
            end
            ST_COMMIT: begin
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
            default: begin
               busy_q  <= 1'b0;
               done_q  <= 1'b0;
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign busy_o = busy_q;
   assign done_o = done_q;
   assign bcd_o  = bcd_q;
   assign ovf_o  = ovf_q;

endmodule

// File: rtl/score_display_mux.sv
// Score display driver: binary load -> BCD conversion -> committed display
// register -> time-multiplexed 7-segment scan with blanking and blink.
module score_display_mux
   import score_disp_pkg::*;
#(
   parameter int N_DIGITS    = 8,
   parameter int VAL_W       = 16,
   parameter int SCAN_DIV    = 100000,
   parameter int BLINK_SCANS = 250
) (
   input  logic                I_clk_100M,
   input  logic                I_rst,
   input  logic [VAL_W-1:0]    I_value,
   input  logic                I_load,
   input  logic                I_blank_lz,
   input  logic                I_blink,
   output logic [N_DIGITS-1:0] O_shift,
   output logic [6:0]          O_data,
   output logic                O_busy,
   output logic                O_ovf
);

   localparam int BCD_W = 4 * N_DIGITS;
   localparam int PRE_W = (SCAN_DIV > 1)    ? $clog2(SCAN_DIV)    : 1;
   localparam int IDX_W = (N_DIGITS > 1)    ? $clog2(N_DIGITS)    : 1;
   localparam int FRM_W = (BLINK_SCANS > 1) ? $clog2(BLINK_SCANS) : 1;

   logic                conv_busy;
   logic                conv_done;
   logic                conv_ovf;
   logic [BCD_W-1:0]    conv_bcd;
   logic                conv_idle;
   logic                conv_start;
   logic [VAL_W-1:0]    conv_val;

   logic                pend_q;
   logic [VAL_W-1:0]    pend_val_q;
   logic [BCD_W-1:0]    disp_q;
   logic                ovf_q;
   logic [PRE_W-1:0]    pre_q;
   logic [IDX_W-1:0]    idx_q;
   logic [FRM_W-1:0]    frm_q;
   logic                phase_off_q;
   logic [N_DIGITS-1:0] shift_q;
   logic [6:0]          data_q;

   logic [3:0]          cur_nib;
   logic                upper_nz;
   logic                blank_d;
   logic [N_DIGITS-1:0] shift_d;
   logic [6:0]          data_d;

   // The converter is free only outside SHIFT and COMMIT; a pending value wins
   // the start slot over a fresh load, which then becomes the new pending value.
   assign conv_idle  = !conv_busy && !conv_done;
   assign conv_start = conv_idle && (pend_q || I_load);
   assign conv_val   = pend_q ? pend_val_q : I_value;

   bin2bcd_seq #(
      .VAL_W    (VAL_W),
      .N_DIGITS (N_DIGITS)
   ) u_conv (
      .clk_i   (I_clk_100M),
      .rst_i   (I_rst),
      .start_i (conv_start),
      .value_i (conv_val),
      .busy_o  (conv_busy),
      .done_o  (conv_done),
      .bcd_o   (conv_bcd),
      .ovf_o   (conv_ovf)
   );

   // Single-entry pending slot: latest load while busy replaces any earlier one.
   always_ff @(posedge I_clk_100M) begin
      if (I_rst) begin
         pend_q     <= 1'b0;
         pend_val_q <= '0;
      end else if (I_load && (!conv_idle || pend_q)) begin
         pend_q     <= 1'b1;
         pend_val_q <= I_value;
      end else if (conv_start) begin
         pend_q     <= 1'b0;
      end
   end

   // Display register changes only on COMMIT; overflow saturates to all nines.
   always_ff @(posedge I_clk_100M) begin
      if (I_rst) begin
         disp_q <= '0;
         ovf_q  <= 1'b0;
      end else if (conv_done) begin
         disp_q <= conv_ovf ? {N_DIGITS{4'h9}} : conv_bcd;
         ovf_q  <= conv_ovf;
      end
   end

   // Prescaler -> digit index -> frame counter -> blink phase.
   always_ff @(posedge I_clk_100M) begin
      if (I_rst) begin
         pre_q       <= '0;
         idx_q       <= '0;
         frm_q       <= '0;
         phase_off_q <= 1'b0;
      end else if (pre_q == PRE_W'(SCAN_DIV - 1)) begin
         pre_q <= '0;
         if (idx_q == IDX_W'(N_DIGITS - 1)) begin
            idx_q <= '0;
            if (frm_q == FRM_W'(BLINK_SCANS - 1)) begin
               frm_q       <= '0;
               phase_off_q <= !phase_off_q;
            end else begin
               frm_q <= frm_q + FRM_W'(1);
            end
         end else begin
            idx_q <= idx_q + IDX_W'(1);
         end
      end else begin
         pre_q <= pre_q + PRE_W'(1);
      end
   end

   // Current digit, leading-zero test over it and all higher digits, and enables.
   always_comb begin
      cur_nib  = '0;
      upper_nz = 1'b0;
      for (int unsigned i = 0; i < N_DIGITS; i++) begin
         if (IDX_W'(i) == idx_q) cur_nib = disp_q[4*i +: 4];
         if ((IDX_W'(i) >= idx_q) && (disp_q[4*i +: 4] != 4'd0)) upper_nz = 1'b1;
      end
      blank_d = I_blank_lz && (idx_q != '0) && !upper_nz;
      shift_d = (I_blink && phase_off_q) ? '1 : ~(N_DIGITS'(1) << idx_q);
      data_d  = blank_d ? SEG_BLANK : seg7(cur_nib);
   end

   // Registered pin drivers.
   always_ff @(posedge I_clk_100M) begin
      if (I_rst) begin
         shift_q <= '1;
         data_q  <= SEG_BLANK;
      end else begin
         shift_q <= shift_d;
         data_q  <= data_d;
      end
   end

   assign O_shift = shift_q;
   assign O_data  = data_q;
   assign O_busy  = conv_busy;
   assign O_ovf   = ovf_q;

endmodule
